gen_rsffr: RTL and testbench
============================

// Module: gen_rsffr
// PURPOSE
//   Generic per-bit set/reset register with asynchronous active-low reset.
//   - Each bit is set by set_in, cleared by rst_in, and otherwise holds its value.
//   - Used across the core and its testbench peripherals for AXI-style handshake flags.
//   - Typical flags: awready, wready, bvalid, arready, rvalid.
//   - qout comes directly from the register; there is no combinational path from set_in/rst_in.
// PARAMETERS
//   DW        default 1             register width in bits, legal range 1..1024
//   rstValue  default {DW{1'b0}}    value loaded into qout while RSTn is low
// PORTS
//   CLK     input   1    clock; all state updates on the rising edge
//   RSTn    input   1    asynchronous active-low reset
//   set_in  input   DW   per-bit set request; bit i = 1 forces qout[i] to 1 at the next edge
//   rst_in  input   DW   per-bit clear request; bit i = 1 forces qout[i] to 0 at the next edge
//   qout    output  DW   registered state
// BEHAVIOUR
//   - Clock and reset: one clock; reset is asynchronous and active-low.
//     - Clock port is CLK and reset port is RSTn.
//     - qout = rstValue immediately on the falling edge of RSTn, and for as long as RSTn = 0.
//     - The first update after RSTn rises is the first rising CLK edge that sees RSTn = 1.
//   - Next-state function, applied per bit on each rising CLK edge with RSTn = 1:
//     - qout_next = set_in | (~rst_in & qout).
//     - Latency is one cycle from a request to qout; the held value is stable otherwise.
//   - Truth table, per bit, for (set, rst):
//     - 00 -> hold
//     - 10 -> 1
//     - 01 -> 0
//     - 11 -> 1 (set wins)
//   - Bits are fully independent; there is no cross-bit coupling.
//   - The behaviour is width-generic; no arithmetic is involved.
//   - Callers normally keep set and rst mutually exclusive, e.g. rst = ~set & cond.
//     - The block does not rely on this; the set-priority rule above is the defined behaviour.
//   - Reset mid-operation: an RSTn assertion at any point overrides pending set/rst.
//     - Those pending requests are lost; qout = rstValue.
//   - X-handling: an X on set_in or rst_in propagates to qout per the next-state equation.
//     - The block does not mask X.
//   - Implementation:
//     - One always @(posedge CLK or negedge RSTn) block, or a generate-per-bit structure.
//     - Plus the optional checker logic below.
// CONFIGURATION
//   - Macro GEN_RSFFR_CONFLICT_CHECK_EN (simulation-only checker).
//   - Defined:
//     - On every rising CLK edge with RSTn = 1, if (set_in & rst_in) != 0, $display an ERROR line.
//     - The line gives %m, $time, and the conflicting bit mask in hex.
//     - Then $finish (the simulation stops).
//     - Also reports an ERROR with the same information if set_in or rst_in contains X/Z.
//     - Functional qout behaviour is identical to the undefined case.
//   - Undefined:
//     - No checker code is compiled.
//     - Conflicts resolve silently with set priority.
//     - The RTL is purely synthesizable.
// TESTING
//   1. Reset: DW=1, rstValue=1, hold RSTn=0 -> qout=1.
//      - Release RSTn with set=rst=0 for 3 cycles -> qout stays 1.
//   2. Set/clear: DW=8, rstValue=0.
//      - set_in=8'hA5 for 1 cycle -> qout=8'hA5 after that edge.
//      - Then rst_in=8'h05 for 1 cycle -> qout=8'hA0.
//      - Then idle -> qout holds 8'hA0.
//   3. Conflict priority (macro undefined): qout=8'h00, set_in=8'h0F, rst_in=8'hFF -> qout=8'h0F.
//   4. Async reset mid-operation: qout=8'hFF, pulse RSTn low between clock edges.
//      - qout=8'h00 before the next edge, with no dependence on CLK.
//      - A set_in=8'h01 asserted during reset is ignored.
//   5. Handshake pattern: DW=1.
//      - set = ~q & valid; rst = ~set & ready & q; valid=1, ready=0.
//      - Expect q: 0 -> 1, then holding at 1.
//      - Raise ready -> q=0 on the next edge.
//   6. Checker (macro defined): drive set_in=rst_in=1 at a clock edge.
//      - ERROR line printed and the simulation finishes.
//      - With set_in=rst_in=1 held only while RSTn=0 -> no error.

Source files
------------

// File: rtl/gen_rsffr.sv
// Per-bit set/reset flag register: set wins over clear, async active-low reset to rstValue.
// Optional simulation-only conflict checker enabled by GEN_RSFFR_CONFLICT_CHECK_EN.
module gen_rsffr #(
  parameter int unsigned     DW       = 1,
  parameter logic [DW-1:0]   rstValue = '0
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [DW-1:0] set_in,
  input  logic [DW-1:0] rst_in,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] qout_q;
  logic [DW-1:0] qout_d;

  always_comb begin
    qout_d = set_in | (~rst_in & qout_q);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      qout_q <= rstValue;
    end else begin
      qout_q <= qout_d;
    end
  end

  assign qout = qout_q;

`ifdef GEN_RSFFR_CONFLICT_CHECK_EN
  logic [DW-1:0] conflict_mask;
  assign conflict_mask = set_in & rst_in;

  always @(posedge CLK) begin
    if (RSTn) begin
      if ($isunknown(set_in) || $isunknown(rst_in)) begin
        $display("ERROR: %m t=%0t set_in/rst_in unknown set=%h rst=%h mask=%h",
                 $time, set_in, rst_in, conflict_mask);
      end else if (|conflict_mask) begin
        $display("ERROR: %m t=%0t set/rst conflict mask=%h", $time, conflict_mask);
        $finish;
      end
    end
  end
`else
  // No checker: simultaneous set and clear resolve silently to set.
`endif

endmodule

// File: tb/tb_gen_rsffr.sv
// Self-checking bench for gen_rsffr: directed cases plus random set/clear traffic
// compared against a per-bit priority model.
module tb_gen_rsffr;

  logic       CLK;
  logic       RSTn;
  logic [7:0] s8, r8, q8;
  logic       s1, r1, q1;

  logic [7:0] m8;
  logic       m1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  gen_rsffr #(.DW(8), .rstValue(8'h00)) dut8 (
    .CLK(CLK), .RSTn(RSTn), .set_in(s8), .rst_in(r8), .qout(q8)
  );

  gen_rsffr #(.DW(1), .rstValue(1'b1)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .set_in(s1), .rst_in(r1), .qout(q1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference: each bit independently -- a request to set gives 1, else a clear gives 0, else hold.
  function automatic logic [7:0] ref8(input logic [7:0] q, input logic [7:0] s, input logic [7:0] r);
    logic [7:0] n;
    for (int unsigned i = 0; i < 8; i++) begin
      if (s[i] === 1'b1)      n[i] = 1'b1;
      else if (r[i] === 1'b1) n[i] = 1'b0;
      else                    n[i] = q[i];
    end
    return n;
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clocked step: drive at the falling edge, update the model at the rising edge, check 1ns later.
  task automatic step(input string tag, input logic [7:0] vs8, input logic [7:0] vr8,
                      input logic vs1, input logic vr1);
    logic [7:0] t8;
    @(negedge CLK);
    s8 = vs8; r8 = vr8; s1 = vs1; r1 = vr1;
    @(posedge CLK);
    if (RSTn) begin
      m8 = ref8(m8, vs8, vr8);
      t8 = ref8({7'b0, m1}, {7'b0, vs1}, {7'b0, vr1});
      m1 = t8[0];
    end
    #1;
    chk8({tag, ".q8"}, q8, m8);
    chk1({tag, ".q1"}, q1, m1);
  endtask

  // Reset pulse placed between clock edges; pending set requests present during reset must be lost.
  task automatic mid_reset(input string tag, input logic [7:0] pend);
    @(posedge CLK);
    #2;
    RSTn = 1'b0;
    s8 = pend; r8 = 8'h00; s1 = 1'b0; r1 = 1'b1;
    m8 = 8'h00; m1 = 1'b1;
    #1;
    chk8({tag, ".async8"}, q8, 8'h00);
    chk1({tag, ".async1"}, q1, 1'b1);
    @(posedge CLK);
    #1;
    chk8({tag, ".held8"}, q8, 8'h00);
    s8 = 8'h00; r1 = 1'b0;
    #2;
    RSTn = 1'b1;
  endtask

  initial begin
    logic v, rdy, hs_set, hs_rst;
    RSTn = 1'b0;
    s8 = 8'h00; r8 = 8'h00; s1 = 1'b0; r1 = 1'b0;
    m8 = 8'h00; m1 = 1'b1;

    // Reset values held while RSTn low, across clock edges
    #23;
    chk8("reset.q8", q8, 8'h00);
    chk1("reset.q1", q1, 1'b1);
    @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) step("idle_after_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    chk1("reset.q1_still_one", q1, 1'b1);

    // Set / clear / hold
    step("set_A5", 8'hA5, 8'h00, 1'b0, 1'b0);
    chk8("set_A5.const", q8, 8'hA5);
    step("clr_05", 8'h00, 8'h05, 1'b0, 1'b0);
    chk8("clr_05.const", q8, 8'hA0);
    step("hold_A0", 8'h00, 8'h00, 1'b0, 1'b0);
    chk8("hold_A0.const", q8, 8'hA0);

    // Set wins over clear
    step("clr_all", 8'h00, 8'hFF, 1'b0, 1'b0);
    step("conflict", 8'h0F, 8'hFF, 1'b0, 1'b0);
    chk8("conflict.const", q8, 8'h0F);

    // Async reset mid-operation
    step("set_FF", 8'hFF, 8'h00, 1'b0, 1'b0);
    mid_reset("midrst", 8'h01);
    step("after_midrst", 8'h00, 8'h00, 1'b0, 1'b0);
    chk8("after_midrst.const", q8, 8'h00);

    // Handshake flag on the 1-bit register
    step("hs_clear", 8'h00, 8'h00, 1'b0, 1'b1);
    chk1("hs_clear.const", q1, 1'b0);
    v = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hs_set = ~m1 & v;
      hs_rst = ~hs_set & rdy & m1;
      step("hs_valid", 8'h00, 8'h00, hs_set, hs_rst);
      chk1("hs_valid.const", q1, 1'b1);
    end
    rdy = 1'b1;
    hs_set = ~m1 & v;
    hs_rst = ~hs_set & rdy & m1;
    step("hs_ready", 8'h00, 8'h00, hs_set, hs_rst);
    chk1("hs_ready.const", q1, 1'b0);

    // Random traffic with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        mid_reset("rnd_rst", 8'($urandom));
      end else begin
        step("rnd", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
